// File: rtl/mult_share_arb_if.sv
// Bundle of requester handshake, shared-multiplier and response signals
// for mult_share_arb. "slave" is the arbiter side, "master" the environment.
interface mult_share_arb_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic                    hold;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic                    mult_rst;
  logic [WIDTH-1:0]        mult_a;
  logic [WIDTH-1:0]        mult_b;
  logic [2*WIDTH-1:0]      mult_res;
  logic [NREQ-1:0]         rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [2*WIDTH-1:0]      rsp_data;
  logic [IDW+1:0]          inflight;

  modport slave (
    input  hold, req_valid, req_a, req_b, mult_res,
    output req_ready, mult_rst, mult_a, mult_b, rsp_valid, rsp_id, rsp_data, inflight
  );

  modport master (
    output hold, req_valid, req_a, req_b, mult_res,
    input  req_ready, mult_rst, mult_a, mult_b, rsp_valid, rsp_id, rsp_data, inflight
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one pipelined multiplier between NREQ requesters.
// A {valid,id} tag pipe of PIPE_LAT stages tracks each issued operand pair
// so the product can be steered back to its owner. The multiplier itself
// is never trusted after reset; only the tag pipe decides what is returned.
module mult_share_arb #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int PIPE_LAT = 5
) (
  input  logic            clk,
  input  logic            reset,
  mult_share_arb_if.slave bus
);

  logic [IDW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]                scan_idx [NREQ];
  logic                          grant_vld;
  logic [IDW-1:0]                grant_id;
  logic [NREQ-1:0]               req_ready_c;
  logic [WIDTH-1:0]              mult_a_c, mult_b_c;
  logic [PIPE_LAT-1:0]           tag_v_q;
  logic [PIPE_LAT-1:0][IDW-1:0]  tag_id_q;
  logic                          ret_vld;
  logic [IDW-1:0]                ret_id;
  logic [NREQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]                rsp_id_q;
  logic [2*WIDTH-1:0]            rsp_data_q;
  logic [IDW+1:0]                inflight_q, inflight_d;

  // Scan order starts just after the last grantee and wraps modulo NREQ.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_scan
      assign scan_idx[gi] = IDW'((int'(rr_ptr_q) + gi + 1) % NREQ);
    end
  endgenerate

  // Pick the first valid requester in scan order; iterating backwards lets
  // the earliest candidate overwrite later ones.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (reset && !bus.hold) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (bus.req_valid[scan_idx[k]]) begin
          grant_vld = 1'b1;
          grant_id  = scan_idx[k];
        end
      end
    end
  end

  // One-hot ready on the winner and operand mux; idle cycles feed zeros.
  always_comb begin
    req_ready_c = '0;
    mult_a_c    = '0;
    mult_b_c    = '0;
    if (grant_vld) begin
      req_ready_c[grant_id] = 1'b1;
      mult_a_c              = bus.req_a[grant_id*WIDTH +: WIDTH];
      mult_b_c              = bus.req_b[grant_id*WIDTH +: WIDTH];
    end
  end

  assign ret_vld  = tag_v_q[PIPE_LAT-1];
  assign ret_id   = tag_id_q[PIPE_LAT-1];
  assign rr_ptr_d = grant_vld ? grant_id : rr_ptr_q;

  // Next-state for the response strobe and the outstanding-operation count.
  always_comb begin
    rsp_valid_d = '0;
    if (ret_vld) begin
      rsp_valid_d[ret_id] = 1'b1;
    end
    inflight_d = inflight_q;
    if (grant_vld && !ret_vld) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!grant_vld && ret_vld) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  // Arbiter pointer and tag pipe; the pipe shifts every cycle because the
  // multiplier has no enable and cannot stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= IDW'(NREQ - 1);
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_v_q  <= {tag_v_q[PIPE_LAT-2:0], grant_vld};
      tag_id_q <= {tag_id_q[PIPE_LAT-2:0], grant_id};
    end
  end

  // Registered response; id/data hold their last values between strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      inflight_q  <= inflight_d;
      if (ret_vld) begin
        rsp_id_q   <= ret_id;
        rsp_data_q <= bus.mult_res;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.mult_a    = mult_a_c;
  assign bus.mult_b    = mult_b_c;
  assign bus.mult_rst  = ~reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: stand-in pipelined multiplier, a transaction
// level reference (round-robin by modular scan, queue of due responses),
// and one task per scenario.
module tb_mult_share_arb;
  localparam int WIDTH    = 8;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int PIPE_LAT = 5;
  localparam int IFW      = IDW + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_share_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  mult_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .PIPE_LAT(PIPE_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier stand-in: PIPE_LAT cycles from operands to product, never reset.
  logic [2*WIDTH-1:0] mpipe [PIPE_LAT];
  always @(posedge clk) begin
    mpipe[0] <= {{WIDTH{1'b0}}, bus.mult_a} * {{WIDTH{1'b0}}, bus.mult_b};
    for (int k = 1; k < PIPE_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign bus.mult_res = mpipe[PIPE_LAT-1];

  // Reference model state.
  typedef struct {
    int                 due;
    logic [IDW-1:0]     id;
    logic [2*WIDTH-1:0] prod;
  } ent_t;
  ent_t               exp_q[$];
  int                 m_last;
  logic [NREQ-1:0]    m_rsp_v;
  logic [IDW-1:0]     m_rsp_id;
  logic [2*WIDTH-1:0] m_rsp_data;
  logic [IFW-1:0]     m_inf;
  int                 cyc = 0;
  int                 errors = 0;
  int                 checks = 0;

  function automatic logic [NREQ-1:0] ref_grant(input logic [NREQ-1:0] v, input int last,
                                                input logic hld, input logic rstn);
    logic [NREQ-1:0] g;
    g = '0;
    if (rstn && !hld) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (last + k) % NREQ;
        if (v[idx] && g == '0) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] g);
    int r;
    r = 0;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Advance one clock: update the reference at the edge, return at negedge.
  task automatic tick();
    logic [NREQ-1:0] g;
    ent_t e;
    int i;
    @(posedge clk);
    cyc++;
    g = ref_grant(bus.req_valid, m_last, bus.hold, reset);
    if (!reset) begin
      m_last = NREQ - 1;
      exp_q.delete();
      m_rsp_v = '0;
      m_rsp_id = '0;
      m_rsp_data = '0;
    end else begin
      m_rsp_v = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        m_rsp_v[e.id] = 1'b1;
        m_rsp_id = e.id;
        m_rsp_data = e.prod;
      end
      if (g != '0) begin
        i = idx_of(g);
        e.due  = cyc + PIPE_LAT;
        e.id   = IDW'(i);
        e.prod = 16'(bus.req_a[i*WIDTH +: WIDTH]) * 16'(bus.req_b[i*WIDTH +: WIDTH]);
        exp_q.push_back(e);
        m_last = i;
      end
    end
    m_inf = IFW'(exp_q.size());
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.hold = 1'b0;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) tick();
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
    end
    checks++;
    if (bus.mult_rst !== 1'b1) begin
      errors++; $display("FAIL reset_mult_rst got=%b exp=1", bus.mult_rst);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.inflight} !== 26'd0) begin
      errors++; $display("FAIL reset_outputs got v=%b id=%0d d=%h inf=%0d exp all zero",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.inflight);
    end
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    #1;
    checks++;
    if (bus.mult_rst !== 1'b0) begin
      errors++; $display("FAIL run_mult_rst got=%b exp=0", bus.mult_rst);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0100;
    bus.req_a[2*WIDTH +: WIDTH] = 8'd13;
    bus.req_b[2*WIDTH +: WIDTH] = 8'd11;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100 || bus.mult_a !== 8'd13 || bus.mult_b !== 8'd11) begin
      errors++; $display("FAIL single_issue got rdy=%b a=%0d b=%0d exp rdy=0100 a=13 b=11",
                         bus.req_ready, bus.mult_a, bus.mult_b);
    end
    tick();
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.inflight !== 4'd1) begin
      errors++; $display("FAIL single_after got rdy=%b inf=%0d exp rdy=0000 inf=1",
                         bus.req_ready, bus.inflight);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== ((k == 5) ? 4'b0100 : 4'b0000) ||
          bus.inflight !== ((k < 5) ? 4'd1 : 4'd0)) begin
        errors++; $display("FAIL single_timing k=%0d got v=%b inf=%0d exp v=%b inf=%0d", k,
                           bus.rsp_valid, bus.inflight, (k == 5) ? 4'b0100 : 4'b0000,
                           (k < 5) ? 1 : 0);
      end
      if (k == 5) begin
        checks++;
        if (bus.rsp_id !== 2'd2 || bus.rsp_data !== 16'd143) begin
          errors++; $display("FAIL single_data got id=%0d d=%0d exp id=2 d=143",
                             bus.rsp_id, bus.rsp_data);
        end
      end
    end
    $display("test_single: 13x11 from requester 2");
  endtask

  task automatic test_all_valid();
    int rc;
    rc = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = 8'(i + 1);
      bus.req_b[i*WIDTH +: WIDTH] = 8'd10;
    end
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      if (k == 12) bus.req_valid = '0;
      #1;
      if (k < 12) begin
        checks++;
        if (bus.req_ready !== (4'b0001 << (k % 4))) begin
          errors++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, bus.req_ready,
                             4'b0001 << (k % 4));
        end
      end
      tick();
      if (bus.rsp_valid !== 4'b0000) begin
        checks++;
        if (bus.rsp_valid !== (4'b0001 << (rc % 4)) ||
            bus.rsp_data !== 16'(10 * (rc % 4 + 1))) begin
          errors++; $display("FAIL rr_result n=%0d got v=%b d=%0d exp v=%b d=%0d", rc,
                             bus.rsp_valid, bus.rsp_data, 4'b0001 << (rc % 4), 10 * (rc % 4 + 1));
        end
        rc++;
      end
      if (k == 11) begin
        checks++;
        if (bus.inflight !== 4'd5) begin
          errors++; $display("FAIL rr_saturate got=%0d exp=5", bus.inflight);
        end
      end
    end
    checks++;
    if (rc != 12 || bus.inflight !== 4'd0) begin
      errors++; $display("FAIL rr_count got n=%0d inf=%0d exp n=12 inf=0", rc, bus.inflight);
    end
    $display("test_all_valid: %0d results", rc);
  endtask

  task automatic test_max();
    logic seen;
    logic [2*WIDTH-1:0] d;
    seen = 1'b0;
    d = '0;
    bus.req_valid = 4'b0001;
    bus.req_a[0 +: WIDTH] = 8'hFF;
    bus.req_b[0 +: WIDTH] = 8'hFF;
    tick();
    bus.req_valid = '0;
    repeat (7) begin
      tick();
      if (bus.rsp_valid[0] === 1'b1) begin
        seen = 1'b1;
        d = bus.rsp_data;
      end
    end
    checks++;
    if (!seen || d !== 16'hFE01) begin
      errors++; $display("FAIL max_operands got seen=%b d=%h exp seen=1 d=fe01", seen, d);
    end
    $display("test_max: FFxFF -> %h", d);
  endtask

  task automatic test_hold();
    int pulses;
    pulses = 0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = 8'($urandom);
      bus.req_b[i*WIDTH +: WIDTH] = 8'($urandom);
    end
    bus.req_valid = 4'b1111;
    repeat (2) begin
      tick();
      if (bus.rsp_valid !== 4'b0000) pulses++;
    end
    bus.hold = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.mult_a !== 8'd0) begin
        errors++; $display("FAIL hold_ready got rdy=%b a=%0d exp rdy=0000 a=0",
                           bus.req_ready, bus.mult_a);
      end
      tick();
      if (bus.rsp_valid !== 4'b0000) pulses++;
    end
    bus.hold = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL hold_resume got=%b exp=1000", bus.req_ready);
    end
    tick();
    if (bus.rsp_valid !== 4'b0000) pulses++;
    bus.req_valid = '0;
    repeat (8) begin
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {m_rsp_v, m_rsp_id, m_rsp_data} ||
          bus.inflight !== m_inf) begin
        errors++; $display("FAIL hold_drain cyc=%0d got v=%b id=%0d d=%h inf=%0d exp v=%b id=%0d d=%h inf=%0d",
                           cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.inflight,
                           m_rsp_v, m_rsp_id, m_rsp_data, m_inf);
      end
      if (bus.rsp_valid !== 4'b0000) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++; $display("FAIL hold_returns got=%0d exp=3", pulses);
    end
    $display("test_hold: %0d results across hold", pulses);
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [2*WIDTH-1:0] d;
    seen = 1'b0;
    d = '0;
    bus.req_valid = 4'b1111;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL midreset_ready got=%b exp=0000", bus.req_ready);
    end
    tick();
    reset = 1'b1;
    bus.req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 4'b0000 || bus.inflight !== 4'd0) begin
        errors++; $display("FAIL midreset_discard k=%0d got v=%b inf=%0d exp v=0000 inf=0",
                           k, bus.rsp_valid, bus.inflight);
      end
    end
    bus.req_valid = 4'b1000;
    bus.req_a[3*WIDTH +: WIDTH] = 8'd7;
    bus.req_b[3*WIDTH +: WIDTH] = 8'd9;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL midreset_issue got=%b exp=1000", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    repeat (7) begin
      tick();
      if (bus.rsp_valid === 4'b1000) begin
        seen = 1'b1;
        d = bus.rsp_data;
      end
    end
    checks++;
    if (!seen || d !== 16'd63 || bus.rsp_id !== 2'd3) begin
      errors++; $display("FAIL midreset_first got seen=%b d=%0d id=%0d exp seen=1 d=63 id=3",
                         seen, d, bus.rsp_id);
    end
    $display("test_reset_mid: first new result %0d", d);
  endtask

  task automatic test_back_to_back();
    logic [2*WIDTH-1:0] got[$];
    int first_cyc, last_cyc;
    first_cyc = -1;
    last_cyc = -1;
    bus.req_valid = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      bus.req_a[1*WIDTH +: WIDTH] = 8'(k);
      bus.req_b[1*WIDTH +: WIDTH] = 8'd3;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
        errors++; $display("FAIL b2b_ready k=%0d got=%b exp=0010", k, bus.req_ready);
      end
      tick();
      if (bus.rsp_valid === 4'b0010) begin
        got.push_back(bus.rsp_data);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    bus.req_valid = '0;
    repeat (8) begin
      tick();
      if (bus.rsp_valid === 4'b0010) begin
        got.push_back(bus.rsp_data);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    checks++;
    if (got.size() != 6 || last_cyc - first_cyc != 5) begin
      errors++; $display("FAIL b2b_count got n=%0d span=%0d exp n=6 span=5", got.size(),
                         last_cyc - first_cyc);
    end
    for (int j = 0; j < got.size(); j++) begin
      checks++;
      if (got[j] !== 16'(3 * (j + 1))) begin
        errors++; $display("FAIL b2b_data j=%0d got=%0d exp=%0d", j, got[j], 3 * (j + 1));
      end
    end
    $display("test_back_to_back: %0d results", got.size());
  endtask

  task automatic test_random();
    logic [NREQ-1:0] eg;
    logic [WIDTH-1:0] ea, eb;
    int i;
    for (int k = 0; k < 300; k++) begin
      reset = ($urandom_range(0, 49) != 0);
      bus.hold = ($urandom_range(0, 7) == 0);
      bus.req_valid = NREQ'($urandom);
      bus.req_a = 32'($urandom);
      bus.req_b = 32'($urandom);
      #1;
      eg = ref_grant(bus.req_valid, m_last, bus.hold, reset);
      ea = '0;
      eb = '0;
      if (eg != '0) begin
        i = idx_of(eg);
        ea = bus.req_a[i*WIDTH +: WIDTH];
        eb = bus.req_b[i*WIDTH +: WIDTH];
      end
      checks++;
      if (bus.req_ready !== eg || bus.mult_a !== ea || bus.mult_b !== eb) begin
        errors++; $display("FAIL rand_issue k=%0d got rdy=%b a=%h b=%h exp rdy=%b a=%h b=%h",
                           k, bus.req_ready, bus.mult_a, bus.mult_b, eg, ea, eb);
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {m_rsp_v, m_rsp_id, m_rsp_data} ||
          bus.inflight !== m_inf) begin
        errors++; $display("FAIL rand_rsp k=%0d got v=%b id=%0d d=%h inf=%0d exp v=%b id=%0d d=%h inf=%0d",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.inflight,
                           m_rsp_v, m_rsp_id, m_rsp_data, m_inf);
      end
    end
    reset = 1'b1;
    bus.hold = 1'b0;
    bus.req_valid = '0;
    repeat (8) begin
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {m_rsp_v, m_rsp_id, m_rsp_data} ||
          bus.inflight !== m_inf) begin
        errors++; $display("FAIL rand_drain cyc=%0d got v=%b d=%h inf=%0d exp v=%b d=%h inf=%0d",
                           cyc, bus.rsp_valid, bus.rsp_data, bus.inflight,
                           m_rsp_v, m_rsp_data, m_inf);
      end
    end
    $display("test_random: 300 cycles");
  endtask

  initial begin
    m_last = NREQ - 1;
    m_rsp_v = '0;
    m_rsp_id = '0;
    m_rsp_data = '0;
    m_inf = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_max();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
